imem_loader: RTL and testbench

- Byte-stream program loader, the write side of the instruction fetch path.
- Receives a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word into instruction memory at word-aligned byte addresses, matching the 8-bit PC stepping by 4.
- Holds the CPU (PC held in reset) until a complete, checksum-verified image is loaded.

---
 rtl/imem_loader_pkg.sv | 20 ++
 rtl/imem_loader_if.sv | 21 ++
 rtl/imem_loader_word_assembler.sv | 34 +++
 rtl/imem_loader.sv | 150 +++++++++++++++
 tb/tb_imem_loader.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding,
// error codes and the default frame marker.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COUNT = 3'd1,
        ST_DATA  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_e;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_COUNT = 2'b01;
    localparam logic [1:0] ERR_CSUM  = 2'b10;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input handshake plus instruction-memory write port of the loader.
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;

    modport master (
        output in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/imem_loader_word_assembler.sv
// Collects four little-endian bytes into a 32-bit word; the completed word is
// presented combinationally alongside the strobe of its fourth byte.
module word_assembler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clear,
    input  logic        i_byte_stb,
    input  logic [7:0]  i_byte,
    output logic        o_word_valid,
    output logic [31:0] o_word
);
    logic [1:0]  r_idx;
    logic [23:0] r_buf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= 2'd0;
        end else if (i_clear) begin
            r_idx <= 2'd0;
        end else if (i_byte_stb) begin
            r_idx <= r_idx + 2'd1;
        end
    end

    // Byte buffer carries data only, so it needs no reset.
    always_ff @(posedge clk) begin
        if (i_byte_stb) begin
            r_buf <= {i_byte, r_buf[23:8]};
        end
    end

    assign o_word_valid = i_byte_stb && (r_idx == 2'd3);
    assign o_word       = {i_byte, r_buf};
endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream program loader: SYNC, count, data words, XOR checksum;
// writes words to instruction memory and releases the CPU once verified.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         ADDR_W      = 8,
    parameter int         DEPTH_WORDS = 64,
    parameter int         BASE_ADDR   = 0,
    parameter logic [7:0] SYNC_BYTE   = DEFAULT_SYNC_BYTE,
    localparam int        WL_W        = $clog2(DEPTH_WORDS + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            restart,
    imem_loader_if.slave    bus,
    output logic            cpu_hold,
    output logic            done,
    output logic            error,
    output logic [1:0]      err_code,
    output logic [WL_W-1:0] words_loaded
);
    localparam logic [2:0] IDLE  = ST_IDLE;
    localparam logic [2:0] COUNT = ST_COUNT;
    localparam logic [2:0] DATA  = ST_DATA;
    localparam logic [2:0] CHECK = ST_CHECK;
    localparam logic [2:0] DONE  = ST_DONE;
    localparam logic [2:0] ERR   = ST_ERR;

    logic [2:0]        r_state;
    logic [WL_W-1:0]   r_count;
    logic [WL_W-1:0]   r_words;
    logic [7:0]        r_csum;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [31:0]       r_wr_data;
    logic              r_hold;
    logic              r_done;
    logic              r_err;
    logic [1:0]        r_code;

    logic              w_open;
    logic              w_acc;
    logic              w_clear;
    logic              w_stb;
    logic              w_word_valid;
    logic [31:0]       w_word;
    logic              w_count_bad;
    logic [WL_W-1:0]   w_words_nxt;

    // Gating with rst keeps any byte from being consumed while in reset.
    assign w_open      = (r_state == IDLE) || (r_state == COUNT) ||
                         (r_state == DATA) || (r_state == CHECK);
    assign bus.in_ready = rst && !restart && w_open;
    assign w_acc       = bus.in_valid && bus.in_ready;
    assign w_clear     = restart || ((r_state == COUNT) && w_acc);
    assign w_stb       = w_acc && (r_state == DATA);
    assign w_count_bad = (bus.in_data == 8'd0) || (int'(bus.in_data) > DEPTH_WORDS);
    assign w_words_nxt = r_words + WL_W'(1);

    word_assembler u_asm (
        .clk          (clk),
        .rst_n        (rst),
        .i_clear      (w_clear),
        .i_byte_stb   (w_stb),
        .i_byte       (bus.in_data),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_words   <= '0;
            r_csum    <= 8'd0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= 32'd0;
            r_hold    <= 1'b1;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_code    <= ERR_NONE;
        end else if (restart) begin
            // Abort: cancels any scheduled strobe, memory keeps partial words.
            r_state   <= IDLE;
            r_words   <= '0;
            r_wr_en   <= 1'b0;
            r_hold    <= 1'b1;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_code    <= ERR_NONE;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_acc && (bus.in_data == SYNC_BYTE)) r_state <= COUNT;
                end
                COUNT: begin
                    if (w_acc) begin
                        if (w_count_bad) begin
                            r_state <= ERR;
                            r_err   <= 1'b1;
                            r_code  <= ERR_COUNT;
                        end else begin
                            r_count <= WL_W'(bus.in_data);
                            r_csum  <= 8'd0;
                            r_words <= '0;
                            r_state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (w_acc) begin
                        r_csum <= r_csum ^ bus.in_data;
                        if (w_word_valid) begin
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= ADDR_W'(BASE_ADDR + 4 * int'(r_words));
                            r_wr_data <= w_word;
                            r_words   <= w_words_nxt;
                            if (w_words_nxt == r_count) r_state <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (w_acc) begin
                        if (bus.in_data == r_csum) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_hold  <= 1'b0;
                        end else begin
                            r_state <= ERR;
                            r_err   <= 1'b1;
                            r_code  <= ERR_CSUM;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.wr_en    = r_wr_en;
    assign bus.wr_addr  = r_wr_addr;
    assign bus.wr_data  = r_wr_data;
    assign cpu_hold     = r_hold;
    assign done         = r_done;
    assign error        = r_err;
    assign err_code     = r_code;
    assign words_loaded = r_words;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a frame-level parser model predicts writes
// and final status; a negedge monitor checks every write strobe against it.
module tb_imem_loader;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 64;
    localparam int WL_W   = $clog2(DEPTH + 1);

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [7:0]  a;
        logic [31:0] d;
    } wr_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            restart = 1'b0;
    logic            cpu_hold, done, error;
    logic [1:0]      err_code;
    logic [WL_W-1:0] words_loaded;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH_WORDS(DEPTH), .BASE_ADDR(0), .SYNC_BYTE(8'hA5)) dut (
        .clk          (clk),
        .rst          (rst),
        .restart      (restart),
        .bus          (bus),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .err_code     (err_code),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int  checks = 0;
    int  passes = 0;
    wr_t exp_q[$];

    wr_t         m_wr[$];
    logic        m_done, m_err;
    logic [1:0]  m_code;
    int          m_words;
    logic [7:0]  m_csum;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Frame parser over the accepted byte sequence, independent of cycle timing.
    task automatic model_run(input bq_t b);
        int phase = 0;
        int n = 0;
        int k = 0;
        logic [31:0] wd = 32'd0;
        m_wr.delete();
        m_done = 1'b0; m_err = 1'b0; m_code = 2'b00; m_words = 0; m_csum = 8'd0;
        foreach (b[i]) begin
            case (phase)
                0: if (b[i] == 8'hA5) phase = 1;
                1: begin
                    if (b[i] == 8'd0 || int'(b[i]) > DEPTH) begin
                        m_err = 1'b1; m_code = 2'b01; phase = 5;
                    end else begin
                        n = int'(b[i]); m_csum = 8'd0; k = 0; m_words = 0; phase = 2;
                    end
                end
                2: begin
                    m_csum = m_csum ^ b[i];
                    wd[8*k +: 8] = b[i];
                    k++;
                    if (k == 4) begin
                        m_wr.push_back('{a: 8'(4 * m_words), d: wd});
                        m_words++;
                        k = 0;
                        if (m_words == n) phase = 3;
                    end
                end
                3: begin
                    if (b[i] == m_csum) m_done = 1'b1;
                    else begin m_err = 1'b1; m_code = 2'b10; end
                    phase = 5;
                end
                default: ;
            endcase
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("hold_vs_done", {31'd0, cpu_hold}, {31'd0, !done});
            if (bus.wr_en) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_wr", 32'd1, 32'd0);
                end else begin
                    wr_t w;
                    w = exp_q.pop_front();
                    chk("wr_addr", {24'd0, bus.wr_addr}, {24'd0, w.a});
                    chk("wr_data", bus.wr_data, w.d);
                end
            end
        end
    end

    task automatic send_frame(input bq_t b, input bit gaps);
        bit ok, rd;
        @(posedge clk); #1;
        foreach (b[i]) begin
            if (gaps) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'hA5;
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            end
            bus.in_valid = 1'b1;
            bus.in_data  = b[i];
            ok = 1'b0;
            for (int n = 0; n < 40 && !ok; n++) begin
                rd = bus.in_ready;
                @(posedge clk); #1;
                ok = rd;
            end
            if (!ok) begin
                chk("accept_timeout", 32'd0, 32'd1);
                bus.in_valid = 1'b0;
                return;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic run_frame(input string tag, input bq_t b, input bit gaps);
        model_run(b);
        foreach (m_wr[i]) exp_q.push_back(m_wr[i]);
        send_frame(b, gaps);
        @(posedge clk); #1;
        chk({tag, "_done"},  {31'd0, done},     {31'd0, m_done});
        chk({tag, "_error"}, {31'd0, error},    {31'd0, m_err});
        chk({tag, "_code"},  {30'd0, err_code}, {30'd0, m_code});
        chk({tag, "_words"}, 32'(words_loaded), 32'(m_words));
        chk({tag, "_hold"},  {31'd0, cpu_hold}, {31'd0, !m_done});
        chk({tag, "_wr_left"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic rearm(input bit valid_hi, input logic [7:0] junk);
        @(posedge clk); #1;
        restart = 1'b1;
        bus.in_valid = valid_hi;
        bus.in_data  = junk;
        #1 chk("ready_in_restart", {31'd0, bus.in_ready}, 32'd0);
        @(posedge clk); #1;
        restart = 1'b0;
        bus.in_valid = 1'b0;
        chk("rearm_state", {27'd0, cpu_hold, done, error, err_code}, 32'h10);
        chk("rearm_words", 32'(words_loaded), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_wr_en"},   {31'd0, bus.wr_en}, 32'd0);
        chk({tag, "_wr_addr"}, {24'd0, bus.wr_addr}, 32'd0);
        chk({tag, "_wr_data"}, bus.wr_data, 32'd0);
        chk({tag, "_flags"},   {27'd0, cpu_hold, done, error, err_code}, 32'h10);
        chk({tag, "_words"},   32'(words_loaded), 32'd0);
        chk({tag, "_ready"},   {31'd0, bus.in_ready}, 32'd0);
    endtask

    bq_t nominal, nominal_bad, garbage, bad0, bad65, pre_restart, pre_reset;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        // XOR of the eight data bytes below is 0xD4.
        nominal     = '{8'hA5, 8'h02, 8'h93, 8'h06, 8'h45, 8'h00, 8'h13, 8'h07, 8'h10, 8'h00, 8'hD4};
        nominal_bad = '{8'hA5, 8'h02, 8'h93, 8'h06, 8'h45, 8'h00, 8'h13, 8'h07, 8'h10, 8'h00, 8'h00};
        garbage     = '{8'h00, 8'hFF, 8'h12, 8'hA5, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01};
        bad0        = '{8'hA5, 8'h00};
        bad65       = '{8'hA5, 8'h41};
        pre_restart = '{8'hA5, 8'h02, 8'h93, 8'h06};
        pre_reset   = '{8'hA5, 8'h02, 8'h93, 8'h06, 8'h45, 8'h00, 8'h13};

        model_run(nominal);
        chk("model_csum", {24'd0, m_csum}, 32'hD4);
        chk("model_nwr", 32'(m_wr.size()), 32'd2);
        chk("model_w0", m_wr[0].d, 32'h0045_0693);
        chk("model_a1", {24'd0, m_wr[1].a}, 32'h04);
        chk("model_w1", m_wr[1].d, 32'h0010_0713);

        #12;
        check_reset_outputs("por");
        @(negedge clk);
        rst = 1'b1;

        run_frame("nominal", nominal, 1'b0);
        chk("nominal_lit_done", {31'd0, done}, 32'd1);
        chk("nominal_lit_words", 32'(words_loaded), 32'd2);
        rearm(1'b0, 8'h00);

        run_frame("garbage", garbage, 1'b0);
        rearm(1'b0, 8'h00);

        run_frame("bad0", bad0, 1'b0);
        chk("bad0_lit_code", {30'd0, err_code}, 32'h1);
        rearm(1'b0, 8'h00);
        run_frame("bad65", bad65, 1'b0);
        rearm(1'b0, 8'h00);

        run_frame("csum", nominal_bad, 1'b0);
        chk("csum_lit_code", {30'd0, err_code}, 32'h2);
        rearm(1'b0, 8'h00);

        run_frame("gaps", nominal, 1'b1);
        rearm(1'b0, 8'h00);

        run_frame("pre_restart", pre_restart, 1'b0);
        rearm(1'b1, 8'h45);
        run_frame("after_restart", nominal, 1'b0);
        rearm(1'b0, 8'h00);

        model_run(pre_reset);
        foreach (m_wr[i]) exp_q.push_back(m_wr[i]);
        send_frame(pre_reset, 1'b0);
        #1 rst = 1'b0;
        #1 check_reset_outputs("midreset");
        chk("midreset_wr_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        run_frame("after_reset", nominal, 1'b1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
